// File: rtl/masked_and_mul3.sv
// masked_and_mul3: 4-share (order-3) Boolean-masked AND gadget.
// Computes a fresh sharing z with XOR(z) = XOR(x) & XOR(y), two-stage pipeline,
// one operation per clock, no handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; clears both pipeline stages
//   x[3:0] shares of operand x (x[i] is share i)
//   y[3:0] shares of operand y (y[i] is share i)
//   r[2:0] fresh uniform random bits, new value every cycle
//   z[3:0] registered shares of the product
module masked_and_mul3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] r,
  output logic [3:0] z
);

  localparam int unsigned NSHARE = 4;
  localparam int unsigned NTERM  = 4;

  // Refresh masks; the four of them XOR to zero so the product is unchanged.
  logic [NSHARE-1:0] mask;

  // Cross products p[i][j] = x[i] & y[j].
  logic [NSHARE-1:0] p [NSHARE];

  // Stage-A term registers, one 4-bit group per output share.
  logic [NTERM-1:0] term_s0;
  logic [NTERM-1:0] term_s1;
  logic [NTERM-1:0] term_s2;
  logic [NTERM-1:0] term_s3;

  // Masks derived from the three fresh random bits.
  always_comb begin
    mask    = '0;
    mask[0] = r[0];
    mask[1] = r[1];
    mask[2] = r[2];
    mask[3] = r[0] ^ r[1] ^ r[2];
  end

  // All sixteen partial products.
  always_comb begin
    for (int i = 0; i < int'(NSHARE); i++) begin
      p[i] = '0;
      for (int j = 0; j < int'(NSHARE); j++) begin
        p[i][j] = x[i] & y[j];
      end
    end
  end

  // Stage A: register each term individually; only the diagonal term is
  // masked, so no two products meet in combinational logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      term_s0 <= '0;
      term_s1 <= '0;
      term_s2 <= '0;
      term_s3 <= '0;
    end else begin
      term_s0 <= {p[0][2], p[1][0], p[0][1], p[0][0] ^ mask[0]};
      term_s1 <= {p[1][3], p[2][1], p[1][2], p[1][1] ^ mask[1]};
      term_s2 <= {p[2][0], p[3][2], p[2][3], p[2][2] ^ mask[2]};
      term_s3 <= {p[3][1], p[0][3], p[3][0], p[3][3] ^ mask[3]};
    end
  end

  // Stage B: compress each share from its own registered terms only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z <= '0;
    end else begin
      z <= {^term_s3, ^term_s2, ^term_s1, ^term_s0};
    end
  end

endmodule

// File: tb/tb_masked_and_mul3.sv
// tb_masked_and_mul3: self-checking bench for masked_and_mul3 using a
// behavioural share-assignment model and a two-deep latency model.
module tb_masked_and_mul3;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] r;
  logic [3:0] z;

  int n_cmp;
  int n_bad;

  // Model pipeline: value that will appear on z after next edge, and current z.
  logic [3:0] mdl_mid;
  logic [3:0] mdl_z;
  logic       par_mid;
  logic       par_z;

  masked_and_mul3 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .y    (y),
    .r    (r),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Expected output shares from the term-to-share assignment table.
  function automatic logic [3:0] ref_z(input logic [3:0] xs, input logic [3:0] ys,
                                       input logic [2:0] rs);
    int pi [16] = '{0, 0, 1, 0, 1, 1, 2, 1, 2, 2, 3, 2, 3, 3, 0, 3};
    int pj [16] = '{0, 1, 0, 2, 1, 2, 1, 3, 2, 3, 2, 0, 3, 0, 3, 1};
    logic [3:0] zz;
    zz = {rs[0] ^ rs[1] ^ rs[2], rs[2], rs[1], rs[0]};
    for (int k = 0; k < 16; k++) zz[k / 4] = zz[k / 4] ^ (xs[pi[k]] & ys[pj[k]]);
    return zz;
  endfunction

  // One clock edge with the given inputs; returns #1 after the edge with the
  // model advanced to what z should now hold.
  task automatic tick(input logic rs_n, input logic [3:0] xs, input logic [3:0] ys,
                      input logic [2:0] rs);
    rst_n = rs_n;
    x     = xs;
    y     = ys;
    r     = rs;
    @(posedge clk);
    if (!rs_n) begin
      mdl_z   = 4'b0000;
      par_z   = 1'b0;
      mdl_mid = 4'b0000;
      par_mid = 1'b0;
    end else begin
      mdl_z   = mdl_mid;
      par_z   = par_mid;
      mdl_mid = ref_z(xs, ys, rs);
      par_mid = (^xs) & (^ys);
    end
    #1;
  endtask

  task automatic tick_rand(input logic rs_n);
    tick(rs_n, 4'($urandom), 4'($urandom), 3'($urandom));
  endtask

  logic [3:0] zbits;
  logic [15:0] seen;
  int          ndist;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    mdl_mid = '0;
    mdl_z   = '0;
    par_mid = 1'b0;
    par_z   = 1'b0;
    rst_n   = 1'b0;
    x       = '0;
    y       = '0;
    r       = '0;

    // Reset for two edges with arbitrary inputs.
    tick_rand(1'b0);
    check("reset_edge1", z, 4'b0000);
    tick_rand(1'b0);
    check("reset_edge2", z, 4'b0000);

    // Release: first sampled data shows up one edge after the release edge.
    tick(1'b1, 4'b0001, 4'b0001, 3'b000);
    check("release_edge1", z, 4'b0000);
    tick(1'b1, 4'b0001, 4'b0001, 3'b111);
    check("release_edge2", z, 4'b0001);
    check("release_model", z, mdl_z);

    // Mask application (issued on the previous tick).
    tick(1'b1, 4'b0011, 4'b0001, 3'b000);
    check("mask_apply", z, 4'b1110);

    // Zero product (issued on the previous tick).
    tick_rand(1'b1);
    check("zero_product", z, 4'b0000);

    // Exhaustive x, y, r sweep back-to-back, checked two edges later.
    for (int v = 0; v < 2048; v++) begin
      tick(1'b1, 4'(v >> 7), 4'(v >> 3), 3'(v));
      check("exh_shares", z, mdl_z);
      zbits = {3'b000, ^z};
      check("exh_parity", zbits, {3'b000, par_z});
    end

    // Mid-stream reset flushes both in-flight operations.
    for (int i = 0; i < 12; i++) begin
      tick_rand(1'b1);
      check("stream_pre", z, mdl_z);
    end
    tick_rand(1'b0);
    check("midrst_edge", z, 4'b0000);
    tick_rand(1'b1);
    check("midrst_after1", z, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      tick_rand(1'b1);
      check("stream_post", z, mdl_z);
    end

    // Randomness: x parity 0 so product 0; shares must vary with r.
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 4'b1111, 4'b1000, 3'(k));
      if (k >= 2) begin
        check("rand_shares", z, mdl_z);
        zbits = {3'b000, ^z};
        check("rand_parity", zbits, 4'b0000);
        seen[z] = 1'b1;
      end
    end
    ndist = 0;
    for (int k = 0; k < 16; k++) if (seen[k]) ndist++;
    zbits = (ndist >= 2) ? 4'b0001 : 4'b0000;
    check("rand_distinct", zbits, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
